// File: rtl/down_counter_timer_pkg.sv
// Shared types and helpers for the down counter timer.
// Optional prescaler is enabled with DOWN_COUNTER_TIMER_PRESCALE_EN.
package down_counter_timer_pkg;

  // Controller state, 1-bit encoded
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Prescaler counter width: $clog2(prescale), never below one bit
  function automatic int unsigned ps_width(input int unsigned prescale);
    int unsigned w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/down_counter_prescaler.sv
// Count-enable divisor: ticks on every PRESCALE-th en-high cycle.
// Only instantiated when DOWN_COUNTER_TIMER_PRESCALE_EN is defined.
module down_counter_prescaler
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic c,
  input  logic r,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = ps_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // Tick on the en-high cycle in which the count wraps
  assign tick = en && (cnt == LAST);

  // En-high cycle counter 0..PRESCALE-1; load clears it, en low freezes it
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down counter with terminal-count pulse, one-shot or auto-reload.
// Define DOWN_COUNTER_TIMER_PRESCALE_EN to divide the count enable by PRESCALE.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             c,
  input  logic             r,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             auto,
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             busy
);

  state_t           state, next_state;
  logic [WIDTH-1:0] reload, next_reload;
  logic [WIDTH-1:0] next_o;
  logic             next_tc;
  logic             step_c;

  // Parameter sanity: empty blocks only exist for illegal settings
  if (WIDTH < 2) begin : g_width_invalid
  end
  if (PRESCALE < 1) begin : g_prescale_invalid
  end

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
  logic ps_tick;

  down_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .c    (c),
    .r    (r),
    .clr  (load),
    .en   (en),
    .tick (ps_tick)
  );

  assign step_c = en && ps_tick;
`else
  assign step_c = en;
`endif

  // Next state and next outputs; load beats counting
  always_comb begin
    next_state  = state;
    next_reload = reload;
    next_o      = o;
    next_tc     = 1'b0;
    if (load) begin
      next_o      = d;
      next_reload = d;
      next_state  = (d != '0) ? RUN : IDLE;
    end else if ((state == RUN) && step_c) begin
      if (o > WIDTH'(1)) begin
        next_o = o - WIDTH'(1);
      end else begin
        next_tc = 1'b1;
        if (auto) begin
          next_o = reload;
        end else begin
          next_o     = '0;
          next_state = IDLE;
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state  <= IDLE;
      reload <= '0;
      o      <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= next_state;
      reload <= next_reload;
      o      <= next_o;
      tc     <= next_tc;
      busy   <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer (WIDTH=4, PRESCALE=4).
module tb_down_counter_timer;

  logic       c;
  logic       r;
  logic       load;
  logic [3:0] d;
  logic       en;
  logic       auto;
  logic [3:0] o;
  logic       tc;
  logic       busy;

  int vectors;
  int errors;

  down_counter_timer #(
    .WIDTH    (4),
    .PRESCALE (4)
  ) dut (
    .c    (c),
    .r    (r),
    .load (load),
    .d    (d),
    .en   (en),
    .auto (auto),
    .o    (o),
    .tc   (tc),
    .busy (busy)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // Advance one rising edge and settle
  task automatic edge1();
    @(posedge c);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    exp = {4'd0, 1'b0, 1'b0};
    vectors++;
    if ({o, tc, busy} !== exp) begin
      errors++;
      $display("FAIL reset {o,tc,busy} got %b want %b", {o, tc, busy}, exp);
    end
    edge1();
    r = 1'b0;
    edge1();
    vectors++;
    if ({o, tc, busy} !== exp) begin
      errors++;
      $display("FAIL reset_idle {o,tc,busy} got %b want %b", {o, tc, busy}, exp);
    end
  endtask

  task automatic test_oneshot();
    logic [5:0] exp [5];
    exp[0] = {4'd3, 1'b0, 1'b1};
    exp[1] = {4'd2, 1'b0, 1'b1};
    exp[2] = {4'd1, 1'b0, 1'b1};
    exp[3] = {4'd0, 1'b1, 1'b0};
    exp[4] = {4'd0, 1'b0, 1'b0};
    auto = 1'b0; en = 1'b1; load = 1'b1; d = 4'd3;
    for (int k = 0; k < 5; k++) begin
      edge1();
      load = 1'b0;
      vectors++;
      if ({o, tc, busy} !== exp[k]) begin
        errors++;
        $display("FAIL oneshot k=%0d {o,tc,busy} got %b want %b", k, {o, tc, busy}, exp[k]);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] eo [10];
    logic       etc;
    eo = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    auto = 1'b1; en = 1'b1; load = 1'b1; d = 4'd3;
    for (int k = 0; k < 10; k++) begin
      edge1();
      load = 1'b0;
      etc = (k == 3) || (k == 6) || (k == 9);
      vectors++;
      if ({o, tc, busy} !== {eo[k], etc, 1'b1}) begin
        errors++;
        $display("FAIL auto k=%0d {o,tc,busy} got %b want %b", k, {o, tc, busy}, {eo[k], etc, 1'b1});
      end
    end
    auto = 1'b0;
  endtask

  task automatic test_pause_collide();
    logic [5:0] exp [7];
    logic       en_v [7];
    logic       ld_v [7];
    exp[0] = {4'd4, 1'b0, 1'b1}; en_v[0] = 1'b1; ld_v[0] = 1'b1;
    exp[1] = {4'd3, 1'b0, 1'b1}; en_v[1] = 1'b1; ld_v[1] = 1'b0;
    exp[2] = {4'd2, 1'b0, 1'b1}; en_v[2] = 1'b1; ld_v[2] = 1'b0;
    exp[3] = {4'd2, 1'b0, 1'b1}; en_v[3] = 1'b0; ld_v[3] = 1'b0;
    exp[4] = {4'd2, 1'b0, 1'b1}; en_v[4] = 1'b0; ld_v[4] = 1'b0;
    exp[5] = {4'd1, 1'b0, 1'b1}; en_v[5] = 1'b1; ld_v[5] = 1'b0;
    exp[6] = {4'd5, 1'b0, 1'b1}; en_v[6] = 1'b1; ld_v[6] = 1'b1;
    auto = 1'b0;
    for (int k = 0; k < 7; k++) begin
      en = en_v[k]; load = ld_v[k];
      d = (k == 0) ? 4'd4 : 4'd5;
      edge1();
      vectors++;
      if ({o, tc, busy} !== exp[k]) begin
        errors++;
        $display("FAIL pause_collide k=%0d {o,tc,busy} got %b want %b", k, {o, tc, busy}, exp[k]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    auto = 1'b0; en = 1'b1; load = 1'b1; d = 4'd9;
    edge1();
    load = 1'b0;
    for (int k = 0; k < 3; k++) edge1();
    vectors++;
    if (o !== 4'd6) begin
      errors++;
      $display("FAIL async_reset_pre o got %0d want 6", o);
    end
    #2 r = 1'b1;
    #1;
    vectors++;
    if ({o, tc, busy} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_now {o,tc,busy} got %b want 000000", {o, tc, busy});
    end
    #2 r = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge1();
      vectors++;
      if ({o, tc, busy} !== 6'b0) begin
        errors++;
        $display("FAIL async_reset_after k=%0d {o,tc,busy} got %b want 000000", k, {o, tc, busy});
      end
    end
  endtask

  task automatic test_edge_values();
    logic [5:0] exp;
    en = 1'b1; auto = 1'b0; load = 1'b1; d = 4'd0;
    for (int k = 0; k < 2; k++) begin
      edge1();
      load = 1'b0;
      vectors++;
      if ({o, tc, busy} !== 6'b0) begin
        errors++;
        $display("FAIL load_zero k=%0d {o,tc,busy} got %b want 000000", k, {o, tc, busy});
      end
    end
    load = 1'b1; d = 4'd15;
    for (int k = 0; k <= 16; k++) begin
      edge1();
      load = 1'b0;
      if (k < 15)       exp = {4'(15 - k), 1'b0, 1'b1};
      else if (k == 15) exp = {4'd0, 1'b1, 1'b0};
      else              exp = {4'd0, 1'b0, 1'b0};
      vectors++;
      if ({o, tc, busy} !== exp) begin
        errors++;
        $display("FAIL load_15 k=%0d {o,tc,busy} got %b want %b", k, {o, tc, busy}, exp);
      end
    end
  endtask

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
  task automatic test_prescaler();
    logic [5:0] exp;
    en = 1'b1; auto = 1'b0; load = 1'b1; d = 4'd2;
    for (int k = 0; k <= 9; k++) begin
      edge1();
      load = 1'b0;
      if (k < 4)       exp = {4'd2, 1'b0, 1'b1};
      else if (k < 8)  exp = {4'd1, 1'b0, 1'b1};
      else if (k == 8) exp = {4'd0, 1'b1, 1'b0};
      else             exp = {4'd0, 1'b0, 1'b0};
      vectors++;
      if ({o, tc, busy} !== exp) begin
        errors++;
        $display("FAIL prescale k=%0d {o,tc,busy} got %b want %b", k, {o, tc, busy}, exp);
      end
    end
  endtask
`endif

  initial begin
    vectors = 0;
    errors  = 0;
    r = 1'b1; load = 1'b0; d = 4'd0; en = 1'b0; auto = 1'b0;
    #1;
    test_reset();
`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
    test_prescaler();
`else
    test_oneshot();
    test_auto_reload();
    test_pause_collide();
    test_async_reset();
    test_edge_values();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
